set_assoc_dcache: RTL

SET_ASSOC_DCACHE -- requirements
Module: set_assoc_dcache

---
 rtl/set_assoc_dcache.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/set_assoc_dcache.sv
// set_assoc_dcache: set-associative, write-back / write-allocate data cache, one request at a time.
// Ports: clk, resetn (async active-low); dreq/dresp = CPU side (addr_ok accept, data_ok one cycle later);
//        creq/cresp = memory side, line bursts of WORDS_PER_LINE beats advanced by cresp.ready, ended by cresp.last.

typedef struct packed {
  logic        valid;
  logic [31:0] addr;
  logic [2:0]  size;
  logic [3:0]  strobe;
  logic [31:0] data;
} dbus_req_t;

typedef struct packed {
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] data;
} dbus_resp_t;

typedef struct packed {
  logic        valid;
  logic        is_write;
  logic [2:0]  size;
  logic [31:0] addr;
  logic [3:0]  strobe;
  logic [31:0] data;
  logic [3:0]  len;
} cbus_req_t;

typedef struct packed {
  logic        ready;
  logic        last;
  logic [31:0] data;
} cbus_resp_t;

module set_assoc_dcache #(
  parameter int NUM_SETS       = 4,
  parameter int NUM_WAYS       = 2,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  localparam int OFS_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int TAG_W = 32 - 2 - OFS_W - IDX_W;

  // len is encoded as beats-1
  localparam logic [3:0]       BURST_LEN = 4'(WORDS_PER_LINE - 1);
  localparam logic [WAY_W-1:0] LAST_WAY  = WAY_W'(NUM_WAYS - 1);
  localparam logic [2:0]       SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL,
    RESPOND
  } state_t;

  state_t state_q, state_d;

  // line state and storage
  logic             valid_q [NUM_SETS][NUM_WAYS];
  logic             dirty_q [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0] tag_q   [NUM_SETS][NUM_WAYS];
  logic [31:0]      data_q  [NUM_SETS][NUM_WAYS][WORDS_PER_LINE];
  logic [WAY_W-1:0] ptr_q   [NUM_SETS];

  // miss context, captured when the miss is detected
  logic [IDX_W-1:0] miss_idx_q;
  logic [TAG_W-1:0] miss_tag_q;
  logic [WAY_W-1:0] way_q;
  logic [OFS_W-1:0] cnt_q;
  logic [31:0]      rdata_q;

  // request address decode
  logic [OFS_W-1:0] req_ofs;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             req_wr;

  assign req_ofs = dreq.addr[2 +: OFS_W];
  assign req_idx = dreq.addr[2 + OFS_W +: IDX_W];
  assign req_tag = dreq.addr[31 -: TAG_W];
  assign req_wr  = |dreq.strobe;

  // size and the byte offset are irrelevant to word/line-granular storage
  logic unused_req_bits;
  assign unused_req_bits = ^{dreq.size, dreq.addr[1:0]};

  // hit detection
  logic             hit;
  logic [WAY_W-1:0] hit_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // victim: lowest invalid way wins (scan downward so the last hit is the lowest), else the set pointer
  logic [WAY_W-1:0] victim;

  always_comb begin
    victim = ptr_q[req_idx];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        victim = WAY_W'(w);
      end
    end
  end

  logic [WAY_W-1:0] ptr_next;
  assign ptr_next = (ptr_q[miss_idx_q] == LAST_WAY) ? '0 : ptr_q[miss_idx_q] + 1'b1;

  // FSM control strobes
  logic accept;
  logic miss_go;
  logic wb_beat;
  logic wb_done;
  logic rf_beat;
  logic rf_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dresp   = '0;
    creq    = '0;
    accept  = 1'b0;
    miss_go = 1'b0;
    wb_beat = 1'b0;
    wb_done = 1'b0;
    rf_beat = 1'b0;
    rf_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          if (hit) begin
            dresp.addr_ok = 1'b1;
            accept        = 1'b1;
            state_d       = RESPOND;
          end else begin
            miss_go = 1'b1;
            state_d = (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) ? WRITEBACK : REFILL;
          end
        end
      end

      WRITEBACK: begin
        creq.valid    = 1'b1;
        creq.is_write = 1'b1;
        creq.size     = SIZE_WORD;
        creq.addr     = {tag_q[miss_idx_q][way_q], miss_idx_q, {(OFS_W + 2){1'b0}}};
        creq.strobe   = 4'hF;
        creq.data     = data_q[miss_idx_q][way_q][cnt_q];
        creq.len      = BURST_LEN;
        if (cresp.ready) begin
          wb_beat = 1'b1;
          if (cresp.last) begin
            wb_done = 1'b1;
            state_d = REFILL;
          end
        end
      end

      REFILL: begin
        creq.valid    = 1'b1;
        creq.is_write = 1'b0;
        creq.size     = SIZE_WORD;
        creq.addr     = {miss_tag_q, miss_idx_q, {(OFS_W + 2){1'b0}}};
        creq.strobe   = 4'h0;
        creq.len      = BURST_LEN;
        if (cresp.ready) begin
          rf_beat = 1'b1;
          if (cresp.last) begin
            rf_done = 1'b1;
            state_d = IDLE;
          end
        end
      end

      RESPOND: begin
        dresp.data_ok = 1'b1;
        dresp.data    = rdata_q;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Control state: valid/dirty/pointers and miss context.
  // The victim is invalidated as soon as it is chosen: its tag and data stay readable for the
  // write-back, and a line that is mid-refill must never look valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
      way_q      <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        ptr_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
        end
      end
    end else begin
      if (miss_go) begin
        miss_idx_q               <= req_idx;
        miss_tag_q               <= req_tag;
        way_q                    <= victim;
        cnt_q                    <= '0;
        valid_q[req_idx][victim] <= 1'b0;
      end

      if (accept && req_wr) begin
        dirty_q[req_idx][hit_way] <= 1'b1;
      end

      // last ends the burst even if the counter has not wrapped
      if (wb_done || rf_done) begin
        cnt_q <= '0;
      end else if (wb_beat || rf_beat) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (wb_done) begin
        dirty_q[miss_idx_q][way_q] <= 1'b0;
      end

      if (rf_done) begin
        valid_q[miss_idx_q][way_q] <= 1'b1;
        dirty_q[miss_idx_q][way_q] <= 1'b0;
        ptr_q[miss_idx_q]          <= ptr_next;
      end
    end
  end

  // Tag/data storage carries no reset; valid bits alone decide whether contents are meaningful.
  always_ff @(posedge clk) begin
    if (accept) begin
      rdata_q <= data_q[req_idx][hit_way][req_ofs];
      for (int b = 0; b < 4; b++) begin
        if (dreq.strobe[b]) begin
          data_q[req_idx][hit_way][req_ofs][8*b +: 8] <= dreq.data[8*b +: 8];
        end
      end
    end

    if (rf_beat) begin
      data_q[miss_idx_q][way_q][cnt_q] <= cresp.data;
    end

    if (rf_done) begin
      tag_q[miss_idx_q][way_q] <= miss_tag_q;
    end
  end

endmodule
